seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Monitor and decoder for the 8-bit seven-segment output bus driven by the team's top-level design.
- Samples the bus and qualifies each new pattern by requiring it to be stable for a set number of cycles.
- Decodes qualified patterns back to a hex nibble and queues them in a small FIFO with a valid/ready pop interface.
- Used on-chip for self-check and in the cocotb bench as a synthesizable scoreboard front end.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted. Legal range 1..255.
- DEPTH, 4: number of FIFO entries. Must be a power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- seg_in  input  8  segment bus: bit7 = dp; bits[6:0] = {g,f,e,d,c,b,a}; active-high.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head when out_valid && out_ready.
- out_digit  output  4  decoded nibble at the FIFO head.
- out_dp  output  1  dp bit of the head entry.
- out_err  output  1  head entry came from an undecodable nonzero pattern.
- overflow  output  1  sticky flag: an accepted pattern was dropped because the FIFO was full.
- accept_cnt  output  8  count of accepted patterns, wraps 255 -> 0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - out_valid = 0, out_digit = 0, out_dp = 0, out_err = 0, overflow = 0, accept_cnt = 0.
  - FIFO is emptied, the sample register is cleared to 0x00, the FSM goes to IDLE, and the last-accepted pattern is set to 0x00.
- Release of reset is taken synchronously at the next clk edge.
- Sample stage: seg_in is registered every cycle into s_reg. All later logic uses s_reg.
- FSM states:
  - IDLE: s_reg equals the last-accepted pattern. If s_reg differs from it, load run_cnt = 1 and go to QUAL.
  - QUAL: if s_reg equals the previous s_reg, increment run_cnt; otherwise reload run_cnt = 1 and stay in QUAL.
  - QUAL to IDLE: when s_reg changes back to the last-accepted pattern, return to IDLE without accepting.
  - Acceptance: when run_cnt reaches STABLE_CYCLES, the pattern is accepted in that same cycle and the FSM returns to IDLE with last-accepted = s_reg.
  - STABLE_CYCLES = 1: acceptance happens on the first cycle the differing pattern sits in s_reg.
- Blank pattern handling:
  - Accepting seg_in[6:0] = 0 (any dp value) updates last-accepted but pushes nothing and does not increment accept_cnt.
  - This means repeated digits must be separated by a blank to be reported twice.
- Accepting a non-blank pattern:
  - Increment accept_cnt (wraps).
  - Push {digit, dp, err} into the FIFO.
- Decode table for seg[6:0] to digit:
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7
  - 0x7F=8, 0x6F=9, 0x77=A, 0x7C=b, 0x39=C, 0x5E=d, 0x79=E, 0x71=F
  - Any other nonzero pattern: digit = 0, err = 1.
- Latency: if seg_in takes a new stable value before rising edge N, the entry is written at edge N+STABLE_CYCLES. out_valid is high after that edge when the FIFO was empty.
- FIFO:
  - First-word fall-through; outputs come directly from the head entry.
  - A pop on a handshake and a push in the same cycle are both performed; count is unchanged.
  - If full with no pop in a cycle where a push is requested, the new entry is dropped and overflow is set.
  - If full and popped in the same cycle as a push, the push succeeds and no overflow occurs.
- When out_valid = 0, out_digit, out_dp and out_err are 0.
- overflow stays set until clr_ovf = 1 at a clock edge. If clr_ovf and a new overflow occur in the same cycle, overflow stays 1 (set wins).
- Reset mid-qualification or mid-FIFO discards all state; no partial entries survive.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK constant.
  - The 16-entry pattern constants.
  - A decode function returning {err, digit}.
  - A typedef for the FIFO entry struct {digit[3:0], dp, err}.
- One sub-module, seg7_fifo, a parameterized FWFT FIFO holding the entry type:
  - Inputs: push, pop.
  - Outputs: full, empty, head.
  - The FIFO does not generate the overflow flag itself; overflow logic stays in the top.

Test Plan:
- Reset, then hold seg_in = 0x06 for 6 cycles (STABLE_CYCLES = 4) -> one entry {digit 1, dp 0, err 0}; out_valid rises at edge N+4; accept_cnt = 1.
- Glitch: 0x5B for 2 cycles, then 0x4F held -> only digit 3 is queued; no entry for 2.
- Sequence 0x86 held, 0x00 held, 0x06 held with out_ready = 1 -> two entries of digit 1: first with dp = 1, second with dp = 0; accept_cnt = 2.
- Undecodable 0x49 held -> entry {digit 0, err 1}.
- out_ready = 0, then 5 distinct digits each held 5 cycles (DEPTH = 4):
  - The 5th entry is dropped and overflow = 1.
  - Draining pops the first four in order.
  - A clr_ovf pulse sets overflow = 0.
- Assert rst low while in QUAL with the FIFO holding 2 entries -> all outputs go to 0 immediately, asynchronously; after release, a held 0x7F yields digit 8 as the sole entry.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture block: pattern table,
// decode helper, FIFO entry type and qualifier FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index of each entry is the hex digit it displays ({g,f,e,d,c,b,a}).
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [3:0] digit;
    logic       dp;
    logic       err;
  } seg_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_QUAL = 1'b1
  } cap_state_t;

  // Returns {err, digit}; unknown nonzero patterns map to digit 0 with err set.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    res = (seg == SEG_BLANK) ? 5'h00 : 5'h10;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[i]) res = {1'b0, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_fifo.sv
// First-word fall-through FIFO of decoded segment entries. A push while full
// is only taken when the head is popped in the same cycle; dropping and flag
// generation are left to the parent.
module seg7_fifo
  import seg7_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  seg_entry_t din,
  output logic       full,
  output logic       empty,
  output seg_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  seg_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: the head is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment bus monitor: registers the bus, qualifies a new pattern after
// STABLE_CYCLES identical samples, decodes it and queues it for the consumer.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | sampled bus matches the last accepted pattern
// QUAL    | a different pattern is being counted toward acceptance
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic       clr_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_dp,
  output logic       out_err,
  output logic       overflow,
  output logic [7:0] accept_cnt
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  cap_state_t state, state_nxt;
  logic [7:0] s_reg;
  logic [7:0] s_prev;
  logic [7:0] last_acc;
  logic [7:0] run_cnt, run_nxt;
  logic       accept;
  logic       push_req;
  logic       pop;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] dec;
  seg_entry_t push_data;
  seg_entry_t head;

  // run_nxt is the length of the current run including this cycle, so a run
  // reaching STABLE_CYCLES is accepted without waiting another edge.
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_reg != last_acc) begin
          run_nxt = 8'd1;
          if (run_nxt >= STABLE_W) accept = 1'b1;
          else                     state_nxt = ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (s_reg == last_acc) begin
          state_nxt = ST_IDLE;
        end else begin
          run_nxt = (s_reg == s_prev) ? run_cnt + 8'd1 : 8'd1;
          if (run_nxt >= STABLE_W) begin
            accept    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dec       = seg_decode(s_reg[6:0]);
  assign push_data = '{digit: dec[3:0], dp: s_reg[7], err: dec[4]};
  assign push_req  = accept && (s_reg[6:0] != SEG_BLANK);
  assign pop       = out_valid && out_ready;
  assign drop      = push_req && fifo_full && !pop;

  seg7_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (push_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign out_valid = !fifo_empty;
  assign out_digit = out_valid ? head.digit : 4'h0;
  assign out_dp    = out_valid ? head.dp    : 1'b0;
  assign out_err   = out_valid ? head.err   : 1'b0;

  // Sample stage, qualifier state, accepted-pattern memory and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_reg      <= 8'h00;
      s_prev     <= 8'h00;
      last_acc   <= 8'h00;
      run_cnt    <= 8'h00;
      state      <= ST_IDLE;
      accept_cnt <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      s_reg   <= seg_in;
      s_prev  <= s_reg;
      state   <= state_nxt;
      run_cnt <= run_nxt;
      if (accept)   last_acc   <= s_reg;
      if (push_req) accept_cnt <= accept_cnt + 8'd1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (STABLE_CYCLES = 4, DEPTH = 4).
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_in;
  logic       clr_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_dp;
  logic       out_err;
  logic       overflow;
  logic [7:0] accept_cnt;

  int total = 0;
  int bad   = 0;

  seg7_capture #(.STABLE_CYCLES(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .clr_ovf    (clr_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digit  (out_digit),
    .out_dp     (out_dp),
    .out_err    (out_err),
    .overflow   (overflow),
    .accept_cnt (accept_cnt)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, leaving the bench 1 ns after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Head view packed as {0, valid, digit, dp, err}.
  task automatic chk_head(input string tag, input logic v, input logic [3:0] d,
                          input logic dp, input logic err);
    chk(tag, {1'b0, out_valid, out_digit, out_dp, out_err}, {1'b0, v, d, dp, err});
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    seg_in    = 8'h00;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    #12;
    chk_head("reset_head", 1'b0, 4'h0, 1'b0, 1'b0);
    chk("reset_ovf", {7'd0, overflow}, 8'd0);
    chk("reset_cnt", accept_cnt, 8'd0);
    rst = 1'b1;
    cyc(2);

    // Single digit 1, held 6 cycles: nothing after N+3, entry after N+4.
    seg_in = 8'h06;
    cyc(4);
    chk_head("lat_n3", 1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1);
    chk_head("lat_n4", 1'b1, 4'h1, 1'b0, 1'b0);
    chk("cnt_1", accept_cnt, 8'd1);
    cyc(1);
    pop_one();
    chk_head("pop_1", 1'b0, 4'h0, 1'b0, 1'b0);

    // Two-cycle glitch of 2 then 3 held: only 3 queued.
    seg_in = 8'h5B;
    cyc(2);
    seg_in = 8'h4F;
    cyc(6);
    chk_head("glitch_head", 1'b1, 4'h3, 1'b0, 1'b0);
    chk("glitch_cnt", accept_cnt, 8'd2);
    pop_one();
    chk_head("glitch_empty", 1'b0, 4'h0, 1'b0, 1'b0);

    // 1 with dp, blank, 1 without dp: two entries, blank not counted.
    seg_in = 8'h86;
    cyc(6);
    seg_in = 8'h00;
    cyc(6);
    seg_in = 8'h06;
    cyc(6);
    chk("dp_cnt", accept_cnt, 8'd4);
    chk_head("dp_first", 1'b1, 4'h1, 1'b1, 1'b0);
    pop_one();
    chk_head("dp_second", 1'b1, 4'h1, 1'b0, 1'b0);
    pop_one();
    chk_head("dp_empty", 1'b0, 4'h0, 1'b0, 1'b0);

    // Undecodable pattern.
    seg_in = 8'h49;
    cyc(6);
    chk_head("err_head", 1'b1, 4'h0, 1'b0, 1'b1);
    chk("err_cnt", accept_cnt, 8'd5);
    pop_one();

    // Fill to DEPTH, then one more is dropped.
    seg_in = 8'h3F; cyc(5);
    seg_in = 8'h5B; cyc(5);
    seg_in = 8'h66; cyc(5);
    seg_in = 8'h7D; cyc(5);
    chk("full_no_ovf", {7'd0, overflow}, 8'd0);
    seg_in = 8'h7F; cyc(5);
    chk("ovf_set", {7'd0, overflow}, 8'd1);
    chk("ovf_cnt", accept_cnt, 8'd10);
    chk_head("drain_0", 1'b1, 4'h0, 1'b0, 1'b0);
    pop_one();
    chk_head("drain_2", 1'b1, 4'h2, 1'b0, 1'b0);
    pop_one();
    chk_head("drain_4", 1'b1, 4'h4, 1'b0, 1'b0);
    pop_one();
    chk_head("drain_6", 1'b1, 4'h6, 1'b0, 1'b0);
    pop_one();
    chk_head("drain_empty", 1'b0, 4'h0, 1'b0, 1'b0);
    chk("ovf_sticky", {7'd0, overflow}, 8'd1);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", {7'd0, overflow}, 8'd0);

    // Two entries queued, then reset while qualifying a third.
    seg_in = 8'h06; cyc(5);
    seg_in = 8'h5B; cyc(5);
    chk_head("pre_rst_head", 1'b1, 4'h1, 1'b0, 1'b0);
    seg_in = 8'h4F; cyc(2);
    #2;
    rst = 1'b0;
    #1;
    chk_head("async_rst_head", 1'b0, 4'h0, 1'b0, 1'b0);
    chk("async_rst_cnt", accept_cnt, 8'd0);
    seg_in = 8'h7F;
    #1;
    rst = 1'b1;
    cyc(4);
    chk_head("post_rst_n3", 1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1);
    chk_head("post_rst_head", 1'b1, 4'h8, 1'b0, 1'b0);
    chk("post_rst_cnt", accept_cnt, 8'd1);
    pop_one();
    chk_head("post_rst_empty", 1'b0, 4'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
